amba3_axi_burst_addr_gen: RTL and testbench

Parametrised AXI3/AXI4 burst address generator. It accepts one AW/AR-style command at a time and expands it into a per-beat stream of address, byte strobe, beat index and last flag, covering FIXED, INCR and WRAP bursts. Illegal bursts are flagged through a per-beat response. It sits behind the slave address channels of the AXI slave BFM and the RTL slave shims, so that every slave shares one burst-arithmetic implementation.

---
 rtl/pkg_amba3.sv | 40 ++++
 rtl/amba3_axi_beat_strb.sv | 33 +++
 rtl/amba3_axi_burst_addr_gen.sv | 177 +++++++++++++++++
 tb/tb_amba3_axi_burst_addr_gen.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_amba3.sv
// Shared AMBA3 AXI types and burst-arithmetic helpers.
//   burst_type_t   : AXI AxBURST encoding
//   resp_type_t    : AXI xRESP encoding
//   fsm_state_t    : burst address generator FSM states
//   BOUNDARY_4K    : INCR bursts must not cross this boundary
//   wrap_len_legal : 1 when len+1 is a legal WRAP beat count (2/4/8/16)
//   beat_bytes     : bytes per beat for an AxSIZE value
package pkg_amba3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } fsm_state_t;

  localparam int BOUNDARY_4K = 4096;

  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // AxSIZE tops out at 7, so 128 bytes fits in 8 bits.
  function automatic logic [7:0] beat_bytes(input logic [2:0] size);
    return 8'(1) << size;
  endfunction

endpackage

// File: rtl/amba3_axi_beat_strb.sv
// Byte-lane mask for one beat.
//   addr : beat address (may be unaligned)
//   size : log2 bytes per beat
//   strb : active lanes, from addr mod NB up to the end of the aligned beat
module amba3_axi_beat_strb
  import pkg_amba3::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [2:0]              size,
  output logic [DATA_WIDTH/8-1:0] strb
);

  localparam int NB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_lo;
  logic [ADDR_WIDTH-1:0] w_hi;

  always_comb begin
    w_bytes = ADDR_WIDTH'(beat_bytes(size));
    w_lo    = addr & ADDR_WIDTH'(NB - 1);
    // Upper lane comes from the aligned address so an unaligned start
    // only trims the low lanes.
    w_hi    = ((addr & ~(w_bytes - 1'b1)) & ADDR_WIDTH'(NB - 1)) + w_bytes - 1'b1;
    for (int i = 0; i < NB; i++) begin
      strb[i] = (ADDR_WIDTH'(i) >= w_lo) && (ADDR_WIDTH'(i) <= w_hi);
    end
  end

endmodule

// File: rtl/amba3_axi_burst_addr_gen.sv
// AXI3/AXI4 burst address generator: expands one AW/AR-style command into
// a per-beat stream of address, strobe, index, last flag and response.
//   aclk, areset              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready       : command handshake
//   cmd_id/addr/len/size/burst: command fields
//   beat_valid/beat_ready     : beat handshake
//   beat_id/addr/strb/idx/last/resp : per-beat outputs
//
// state    | meaning
// ST_IDLE  | no burst held, ready for a command
// ST_BURST | presenting beats of the latched command
module amba3_axi_burst_addr_gen
  import pkg_amba3::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [ID_WIDTH-1:0]     beat_id,
  output logic [ADDR_WIDTH-1:0]   beat_addr,
  output logic [DATA_WIDTH/8-1:0] beat_strb,
  output logic [LEN_WIDTH-1:0]    beat_idx,
  output logic                    beat_last,
  output logic [1:0]              beat_resp
);

  localparam int           NB         = DATA_WIDTH / 8;
  localparam logic [7:0]   NB_B       = 8'(NB);
  localparam int           PAGE_SHIFT = $clog2(BOUNDARY_4K);

  fsm_state_t            r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_idx;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_illegal;
  logic [ADDR_WIDTH-1:0] r_wrap_lower;
  logic [ADDR_WIDTH-1:0] r_wrap_end;
  logic [NB-1:0]         r_strb;

  logic                  w_beat_hs, w_last, w_cmd_ready, w_cmd_hs, w_illegal;
  logic [ADDR_WIDTH-1:0] w_cmd_bytes, w_cmd_aligned, w_cmd_wsize, w_cmd_last_byte;
  logic [ADDR_WIDTH-1:0] w_cmd_lower;
  logic [ADDR_WIDTH-1:0] w_bytes, w_wrap_nxt, w_next_addr;
  logic [ADDR_WIDTH-1:0] w_strb_addr;
  logic [2:0]            w_strb_size;
  logic [NB-1:0]         w_strb;

  assign w_beat_hs   = (r_state == ST_BURST) && beat_ready;
  assign w_last      = (r_idx == r_len);
  assign w_cmd_ready = !areset && ((r_state == ST_IDLE) || (w_beat_hs && w_last));
  assign w_cmd_hs    = cmd_valid && w_cmd_ready;

  // Legality of the incoming command, latched with the burst.
  always_comb begin
    w_cmd_bytes     = ADDR_WIDTH'(beat_bytes(cmd_size));
    w_cmd_aligned   = cmd_addr & ~(w_cmd_bytes - 1'b1);
    w_cmd_wsize     = w_cmd_bytes * (ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1));
    w_cmd_last_byte = w_cmd_aligned + w_cmd_wsize - 1'b1;
    w_cmd_lower     = cmd_addr & ~(w_cmd_wsize - 1'b1);
    w_illegal       = (cmd_burst == BURST_RSVD) || (beat_bytes(cmd_size) > NB_B);
    if (cmd_burst == BURST_WRAP) begin
      w_illegal = w_illegal || !wrap_len_legal(8'(cmd_len)) ||
                  ((cmd_addr & (w_cmd_bytes - 1'b1)) != '0);
    end
    if (cmd_burst == BURST_INCR) begin
      w_illegal = w_illegal || ((cmd_addr >> PAGE_SHIFT) != (w_cmd_last_byte >> PAGE_SHIFT));
    end
  end

  // Address of the beat following the current one.
  always_comb begin
    w_bytes     = ADDR_WIDTH'(beat_bytes(r_size));
    w_wrap_nxt  = r_addr + w_bytes;
    w_next_addr = r_addr;
    if (!r_illegal) begin
      case (r_burst)
        BURST_INCR: w_next_addr = (r_addr & ~(w_bytes - 1'b1)) + w_bytes;
        BURST_WRAP: w_next_addr = (w_wrap_nxt == r_wrap_end) ? r_wrap_lower : w_wrap_nxt;
        default:    w_next_addr = r_addr;
      endcase
    end
  end

  // One strobe unit serves both the first beat (from the command) and the
  // following beats (from the next address).
  assign w_strb_addr = w_cmd_hs ? cmd_addr : w_next_addr;
  assign w_strb_size = w_cmd_hs ? cmd_size : r_size;

  amba3_axi_beat_strb #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_beat_strb (
    .addr (w_strb_addr),
    .size (w_strb_size),
    .strb (w_strb)
  );

  always_ff @(posedge aclk) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_cmd_hs) w_state_nxt = ST_BURST;
      ST_BURST: if (w_beat_hs && w_last && !w_cmd_hs) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_id         <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
      r_illegal    <= 1'b0;
      r_wrap_lower <= '0;
      r_wrap_end   <= '0;
      r_strb       <= '0;
    end else if (w_cmd_hs) begin
      r_id         <= cmd_id;
      r_addr       <= cmd_addr;
      r_len        <= cmd_len;
      r_idx        <= '0;
      r_size       <= cmd_size;
      r_burst      <= cmd_burst;
      r_illegal    <= w_illegal;
      r_wrap_lower <= w_cmd_lower;
      r_wrap_end   <= w_cmd_lower + w_cmd_wsize;
      r_strb       <= w_illegal ? '0 : w_strb;
    end else if (w_beat_hs && !w_last) begin
      r_idx        <= r_idx + LEN_WIDTH'(1);
      r_addr       <= w_next_addr;
      r_strb       <= r_illegal ? '0 : w_strb;
    end
  end

  always_comb begin
    cmd_ready  = w_cmd_ready;
    beat_valid = 1'b0;
    beat_id    = '0;
    beat_addr  = '0;
    beat_strb  = '0;
    beat_idx   = '0;
    beat_last  = 1'b0;
    beat_resp  = RESP_OKAY;
    if (!areset && (r_state == ST_BURST)) begin
      beat_valid = 1'b1;
      beat_id    = r_id;
      beat_addr  = r_addr;
      beat_strb  = r_strb;
      beat_idx   = r_idx;
      beat_last  = w_last;
      beat_resp  = r_illegal ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_amba3_axi_burst_addr_gen.sv
// Self-checking bench for amba3_axi_burst_addr_gen (32-bit address/data,
// AXI3 length). A reference model expands each accepted command into its
// expected beats; a negedge monitor compares every presented beat.
module tb_amba3_axi_burst_addr_gen;

  localparam int NB = 4;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [3:0]  idx;
    logic        last;
    logic [1:0]  resp;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid;
  logic        beat_ready = 1'b0;
  logic [3:0]  beat_id;
  logic [31:0] beat_addr;
  logic [3:0]  beat_strb;
  logic [3:0]  beat_idx;
  logic        beat_last;
  logic [1:0]  beat_resp;

  int n_total = 0;
  int n_bad   = 0;

  bit    rand_mode   = 1'b0;
  bit    ready_force = 1'b1;
  beat_t exp_q[$];
  bit    prev_cmd_hs = 1'b0;
  bit    prev_stall  = 1'b0;
  logic [47:0] saved;
  bit    acc_on_last;

  amba3_axi_burst_addr_gen #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .LEN_WIDTH  (4),
    .ID_WIDTH   (4)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_id    (beat_id),
    .beat_addr  (beat_addr),
    .beat_strb  (beat_strb),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .beat_resp  (beat_resp)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #2;
    beat_ready = rand_mode ? ($urandom_range(3) != 0) : ready_force;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference expansion of one command into its beats.
  function automatic void model_cmd(input logic [3:0] id, input logic [31:0] addr,
                                    input logic [3:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
    longint unsigned bytes, aligned, wsize, lower, a, last_byte, lo, hi, cnt;
    bit    bad;
    beat_t e;
    cnt       = longint'(len) + 1;
    bytes     = 64'd1 << size;
    aligned   = (longint'(addr) / bytes) * bytes;
    wsize     = bytes * cnt;
    last_byte = (aligned + wsize - 1) % (64'd1 << 32);
    bad = (burst == 2'b11) || (bytes > NB);
    if (burst == 2'b10) bad = bad || !(cnt inside {2, 4, 8, 16}) || (longint'(addr) % bytes != 0);
    if (burst == 2'b01) bad = bad || ((longint'(addr) >> 12) != (last_byte >> 12));
    lower = (longint'(addr) / wsize) * wsize;
    for (int n = 0; n < int'(cnt); n++) begin
      if (bad || burst == 2'b00) a = addr;
      else if (burst == 2'b01)   a = (n == 0) ? longint'(addr) : (aligned + n * bytes) % (64'd1 << 32);
      else                       a = lower + ((longint'(addr) - lower + n * bytes) % wsize);
      e.id   = id;
      e.addr = a[31:0];
      e.strb = '0;
      if (!bad) begin
        lo = a % NB;
        hi = ((a / bytes) * bytes) % NB + bytes - 1;
        for (int l = 0; l < NB; l++) if (l >= lo && l <= hi) e.strb[l] = 1'b1;
      end
      e.idx  = 4'(n);
      e.last = (n == int'(cnt) - 1);
      e.resp = bad ? 2'b10 : 2'b00;
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge aclk) begin
    beat_t e;
    if (areset) begin
      exp_q.delete();
      prev_cmd_hs = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_cmd_hs) begin
        chk("beat0_latency_valid", beat_valid, 1'b1);
        chk("beat0_latency_idx", beat_idx, 4'd0);
      end
      if (prev_stall)
        chk("stall_hold", {beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_resp}, saved);
      if (beat_valid) begin
        chk("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          chk("beat_id", beat_id, e.id);
          chk("beat_addr", beat_addr, e.addr);
          chk("beat_strb", beat_strb, e.strb);
          chk("beat_idx", beat_idx, e.idx);
          chk("beat_last", beat_last, e.last);
          chk("beat_resp", beat_resp, e.resp);
          if (beat_ready) void'(exp_q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) model_cmd(cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst);
      prev_cmd_hs = cmd_valid && cmd_ready;
      prev_stall  = beat_valid && !beat_ready;
      saved = {beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_resp};
    end
  end

  // Called just after a rising edge; returns just after the edge that
  // accepted the command.
  task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
    for (int k = 0; k < 300; k++) begin
      @(negedge aclk);
      if (cmd_ready) begin
        acc         = 1'b1;
        acc_on_last = beat_valid && beat_last;
        break;
      end
    end
    chk("cmd_accepted", acc, 1'b1);
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge aclk);
      if (!beat_valid && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", done, 1'b1);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    logic [3:0]  ln;
    logic [1:0]  bt;
    int          r;

    areset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_id    = '0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_size  = '0;
    cmd_burst = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_outputs", {cmd_ready, beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_resp}, '0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_after_reset", cmd_ready, 1'b1);
    chk("idle_after_reset", beat_valid, 1'b0);
    @(posedge aclk);
    #1;

    // Directed bursts from the feature list.
    send_cmd(4'h1, 32'h0000_1004, 4'd3, 3'd2, 2'b01); wait_idle();
    send_cmd(4'h2, 32'h0000_1001, 4'd1, 3'd2, 2'b01); wait_idle();
    send_cmd(4'h3, 32'h0000_0038, 4'd3, 3'd2, 2'b10); wait_idle();
    send_cmd(4'h4, 32'h0000_0022, 4'd2, 3'd1, 2'b00); wait_idle();
    send_cmd(4'h5, 32'h0000_0040, 4'd2, 3'd2, 2'b10); wait_idle();
    send_cmd(4'h6, 32'h0000_0FF8, 4'd3, 3'd2, 2'b01); wait_idle();
    send_cmd(4'h7, 32'h0000_0100, 4'd1, 3'd3, 2'b01); wait_idle();
    send_cmd(4'h8, 32'h0000_0200, 4'd0, 3'd2, 2'b11); wait_idle();
    send_cmd(4'h9, 32'h0000_0300, 4'd0, 3'd0, 2'b01); wait_idle();

    // Backpressure mid-burst.
    send_cmd(4'hA, 32'h0000_2000, 4'd7, 3'd2, 2'b01);
    @(posedge aclk); #1;
    ready_force = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    ready_force = 1'b1;
    wait_idle();

    // Back-to-back: second command accepted on the last-beat handshake.
    send_cmd(4'hB, 32'h0000_3000, 4'd3, 3'd2, 2'b01);
    send_cmd(4'hC, 32'h0000_3100, 4'd1, 3'd1, 2'b01);
    chk("b2b_accept_on_last", acc_on_last, 1'b1);
    wait_idle();

    // Reset during beat 2 of a 16-beat INCR.
    send_cmd(4'hD, 32'h0000_4000, 4'd15, 3'd2, 2'b01);
    for (int k = 0; k < 40; k++) begin
      if (beat_valid && beat_idx == 4'd2) break;
      @(posedge aclk); #1;
    end
    chk("reached_beat2", beat_valid && (beat_idx == 4'd2), 1'b1);
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("rst_mid_valid", beat_valid, 1'b0);
    chk("rst_mid_ready", cmd_ready, 1'b0);
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_release_ready", cmd_ready, 1'b1);
    chk("rst_release_no_stale", beat_valid, 1'b0);
    @(posedge aclk); #1;
    send_cmd(4'hE, 32'h0000_5000, 4'd2, 3'd2, 2'b01);
    wait_idle();

    // Randomized commands with random consumer backpressure.
    rand_mode = 1'b1;
    for (int t = 0; t < 80; t++) begin
      r  = $urandom_range(9);
      bt = (r < 2) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      sz = ($urandom_range(9) == 0) ? 3'd3 : 3'($urandom_range(2));
      ln = 4'($urandom_range(15));
      a  = $urandom;
      if ($urandom_range(3) == 0) a = (a & 32'hFFFF_F000) | (32'h0000_0FC0 + 32'($urandom_range(63)));
      if (bt == 2'b10 && $urandom_range(3) != 0) begin
        a  = a & ~((32'd1 << sz) - 32'd1);
        r  = $urandom_range(3);
        ln = (r == 0) ? 4'd1 : (r == 1) ? 4'd3 : (r == 2) ? 4'd7 : 4'd15;
      end
      send_cmd(4'($urandom_range(15)), a, ln, sz, bt);
      if ($urandom_range(3) == 0) wait_idle();
    end
    wait_idle();
    rand_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
